// File: rtl/updown_counter_param_pkg.sv
// counter_pkg: shared boundary-action enum and max-value helper for updown_counter_param
package counter_pkg;

    typedef enum logic [1:0] {
        WRAP,
        SATURATE,
        RELOAD
    } bound_act_e;

    // Widest counter the max-value helper can describe
    localparam int MAX_W = 256;

    function automatic logic [MAX_W-1:0] max_val(input int w);
        return ({{(MAX_W-1){1'b0}}, 1'b1} << w) - 1'b1;
    endfunction

endpackage

// File: rtl/updown_counter_param_if.sv
// updown_counter_param_if: load/step request bus and registered count status
interface updown_counter_param_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] in;
    logic             latch;
    logic             inc;
    logic             dec;
    logic             sat;
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             tc;

    modport master (
        output in, latch, inc, dec, sat,
        input  count, zero, tc
    );

    modport slave (
        input  in, latch, inc, dec, sat,
        output count, zero, tc
    );
endinterface

// File: rtl/updown_counter_param_prescaler.sv
// count_prescaler: emits one step per DIV enabled cycles; clear discards the partial count
module count_prescaler #(
    parameter int DIV   = 1,
    parameter int DIV_W = $clog2(DIV + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic step
);
    logic [DIV_W-1:0] r_cnt;

    // With DIV = 1 the counter never leaves 0, so step collapses to en
    assign step = en && (r_cnt == DIV_W'(DIV - 1));

    // Count enabled cycles, restarting on a step or a clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= clear ? '0 : !en ? r_cnt : step ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: loadable up/down counter with prescaler, wrap/saturate and tc pulse
// Optional macro COUNTER_AUTORELOAD_EN: down-step at 0 reloads the last latched value
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIV   = 1,
    parameter int DIV_W = $clog2(DIV + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    updown_counter_param_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_val(WIDTH));

    logic [WIDTH-1:0] r_count;
    logic             r_zero;
    logic             r_tc;
    logic [WIDTH-1:0] w_reload;
    logic             w_reload_en;
    logic             w_en;
    logic             w_step;
    logic             w_up;
    logic             w_at_bound;
    bound_act_e       w_act;
    logic [WIDTH-1:0] w_bound;
    logic [WIDTH-1:0] w_next;

`ifdef COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] r_reload;

    // Remember every latched value as the down-count reload target
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_reload <= '0;
        end else if (bus.latch) begin
            r_reload <= bus.in;
        end
    end

    assign w_reload    = r_reload;
    assign w_reload_en = 1'b1;
`else
    assign w_reload    = '0;
    assign w_reload_en = 1'b0;
`endif

    // inc and dec together cancel out, and a latch suppresses stepping
    assign w_en = !bus.latch && (bus.inc ^ bus.dec);
    assign w_up = bus.inc;

    count_prescaler #(
        .DIV   (DIV),
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (bus.latch),
        .en      (w_en),
        .step    (w_step)
    );

    // Decide what a step at the boundary does and where the count goes next
    always_comb begin
        w_at_bound = w_up ? (r_count == MAX) : (r_count == '0);
        w_act      = (!w_up && w_reload_en) ? RELOAD : bus.sat ? SATURATE : WRAP;
        w_bound    = (w_act == RELOAD) ? w_reload : (w_act == SATURATE) ? r_count : w_up ? '0 : MAX;
        w_next     = bus.latch ? bus.in : !w_step ? r_count : w_at_bound ? w_bound : w_up ? r_count + 1'b1 : r_count - 1'b1;
    end

    // Register count with zero derived from the same next value, and pulse tc on boundary steps
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_zero  <= 1'b1;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_next;
            r_zero  <= (w_next == '0);
            r_tc    <= w_step && w_at_bound;
        end
    end

    assign bus.count = r_count;
    assign bus.zero  = r_zero;
    assign bus.tc    = r_tc;
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed checks of load, step, boundary, prescale and reset behaviour
module tb_updown_counter_param;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   tc_seen;

    updown_counter_param_if #(.WIDTH(32)) b1 ();
    updown_counter_param_if #(.WIDTH(32)) b4 ();

    updown_counter_param #(.WIDTH(32), .DIV(1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (b1.slave)
    );

    updown_counter_param #(.WIDTH(32), .DIV(4)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (b4.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drv1(input logic [31:0] v, input logic l, input logic u, input logic d, input logic s);
        b1.in = v; b1.latch = l; b1.inc = u; b1.dec = d; b1.sat = s;
    endtask

    task automatic drv4(input logic [31:0] v, input logic l, input logic u, input logic d, input logic s);
        b4.in = v; b4.latch = l; b4.inc = u; b4.dec = d; b4.sat = s;
    endtask

    initial begin
        drv1(0, 0, 0, 0, 0);
        drv4(0, 0, 0, 0, 0);
        #12;
        chk("rst_count", b1.count, 32'd0);
        chk("rst_zero", {31'd0, b1.zero}, 32'd1);
        chk("rst_tc", {31'd0, b1.tc}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_hold", b1.count, 32'd0);

        drv1(32'h5555_5555, 1, 0, 0, 0);
        tick();
        chk("load_count", b1.count, 32'h5555_5555);
        chk("load_zero", {31'd0, b1.zero}, 32'd0);
        drv1(0, 0, 0, 1, 0);
        tc_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            tc_seen += int'(b1.tc);
        end
        chk("dec100_count", b1.count, 32'h5555_54F1);
        chk("dec100_zero", {31'd0, b1.zero}, 32'd0);
        chk("dec100_tc_never", tc_seen, 32'd0);

`ifdef COUNTER_AUTORELOAD_EN
        drv1(32'd2, 1, 0, 0, 1);
        tick();
        drv1(0, 0, 0, 1, 1);
        tick(); chk("ar_1", b1.count, 32'd1); chk("ar_1_tc", {31'd0, b1.tc}, 32'd0);
        tick(); chk("ar_0", b1.count, 32'd0); chk("ar_0_zero", {31'd0, b1.zero}, 32'd1);
        tick(); chk("ar_2", b1.count, 32'd2); chk("ar_2_tc", {31'd0, b1.tc}, 32'd1);
        chk("ar_2_zero", {31'd0, b1.zero}, 32'd0);
        tick(); chk("ar_1b", b1.count, 32'd1); chk("ar_1b_tc", {31'd0, b1.tc}, 32'd0);
        tick(); chk("ar_0b", b1.count, 32'd0);
        tick(); chk("ar_2b", b1.count, 32'd2); chk("ar_2b_tc", {31'd0, b1.tc}, 32'd1);
`else
        drv1(32'd0, 1, 0, 0, 0);
        tick();
        chk("wrap_load0_zero", {31'd0, b1.zero}, 32'd1);
        drv1(0, 0, 0, 1, 0);
        tick();
        chk("wrap_down_count", b1.count, 32'hFFFF_FFFF);
        chk("wrap_down_tc", {31'd0, b1.tc}, 32'd1);
        chk("wrap_down_zero", {31'd0, b1.zero}, 32'd0);
        drv1(0, 0, 0, 0, 0);
        tick();
        chk("wrap_tc_one_cycle", {31'd0, b1.tc}, 32'd0);

        drv1(32'd1, 1, 0, 0, 1);
        tick();
        drv1(0, 0, 0, 1, 1);
        tick();
        chk("sat_s1_count", b1.count, 32'd0);
        chk("sat_s1_zero", {31'd0, b1.zero}, 32'd1);
        chk("sat_s1_tc", {31'd0, b1.tc}, 32'd0);
        tick();
        chk("sat_s2_count", b1.count, 32'd0);
        chk("sat_s2_tc", {31'd0, b1.tc}, 32'd1);
        tick();
        chk("sat_s3_count", b1.count, 32'd0);
        chk("sat_s3_tc", {31'd0, b1.tc}, 32'd1);
        drv1(0, 0, 0, 0, 1);
        tick();
        chk("sat_tc_drop", {31'd0, b1.tc}, 32'd0);
`endif

        drv1(32'hFFFF_FFFE, 1, 1, 0, 0);
        tick();
        chk("latch_beats_inc", b1.count, 32'hFFFF_FFFE);
        drv1(0, 0, 1, 0, 0);
        tick();
        chk("up_to_max", b1.count, 32'hFFFF_FFFF);
        chk("up_to_max_tc", {31'd0, b1.tc}, 32'd0);
        drv1(0, 0, 1, 0, 1);
        tick();
        chk("up_sat_count", b1.count, 32'hFFFF_FFFF);
        chk("up_sat_tc", {31'd0, b1.tc}, 32'd1);
        drv1(0, 0, 1, 0, 0);
        tick();
        chk("up_wrap_count", b1.count, 32'd0);
        chk("up_wrap_tc", {31'd0, b1.tc}, 32'd1);
        chk("up_wrap_zero", {31'd0, b1.zero}, 32'd1);

        drv4(32'd10, 1, 0, 0, 0);
        tick();
        chk("d4_load", b4.count, 32'd10);
        drv4(0, 0, 0, 1, 0);
        tick(); tick(); tick();
        chk("d4_after3", b4.count, 32'd10);
        tick();
        chk("d4_after4", b4.count, 32'd9);
        tick(); tick(); tick();
        chk("d4_after7", b4.count, 32'd9);
        tick();
        chk("d4_after8", b4.count, 32'd8);
        drv4(0, 0, 1, 1, 0);
        tick(); tick(); tick();
        chk("d4_both_hold", b4.count, 32'd8);
        drv4(0, 0, 0, 1, 0);
        tick(); tick();
        drv4(32'd10, 1, 0, 0, 0);
        tick();
        drv4(0, 0, 0, 1, 0);
        tick(); tick(); tick();
        chk("d4_latch_clears_pre", b4.count, 32'd10);
        tick();
        chk("d4_latch_then4", b4.count, 32'd9);

        drv1(32'd50, 1, 0, 0, 0);
        tick();
        drv1(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("mid_count", b1.count, 32'd45);
        drv4(0, 0, 0, 1, 1);
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_count", b1.count, 32'd0);
        chk("arst_zero", {31'd0, b1.zero}, 32'd1);
        chk("arst_tc", {31'd0, b1.tc}, 32'd0);
        chk("arst_count4", b4.count, 32'd0);
        drv1(0, 0, 0, 1, 0);
        #1 reset_n = 1'b1;
        tick();
        chk("post_rst_step", b1.count, 32'hFFFF_FFFF);
        tick(); tick();
        chk("pre4_discard_tc", {31'd0, b4.tc}, 32'd0);
        tick();
        chk("pre4_step_tc", {31'd0, b4.tc}, 32'd1);
        chk("pre4_step_count", b4.count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
